trigonometry_unit: RTL and testbench

Registered cosine/sine generator for the hybrid-control path. It takes a signed integer angle in degrees and returns cos θ and sin θ as signed 32-bit integers scaled by 1000. The controller multiplies these values with its scaled state variables to evaluate the switching-surface half-plane. The implementation uses a 91-entry quarter-wave table with quadrant folding.

---
 rtl/trig_pkg.sv | 32 +++
 rtl/trig_quarter_rom.sv | 19 +
 rtl/trigonometry_unit.sv | 100 ++++++++++
 tb/tb_trigonometry_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared constants, quadrant type and the quarter-wave sine table for the trigonometry unit.
// The table is also the golden reference used by verification.
package trig_pkg;

    localparam int AMP       = 1000;
    localparam int ANGLE_MAX = 360;
    localparam int QUARTER   = 90;
    localparam int MAG_W     = 11;
    localparam int ADDR_W    = 7;

    typedef enum logic [1:0] {
        QuadI,
        QuadII,
        QuadIII,
        QuadIV
    } quadrant_e;

    // T[k] = round(1000 * sin(k deg)), k = 0..90
    localparam logic [MAG_W-1:0] SIN_TABLE [0:QUARTER] = '{
        11'd0,   11'd17,  11'd35,  11'd52,  11'd70,  11'd87,  11'd105, 11'd122, 11'd139, 11'd156,
        11'd174, 11'd191, 11'd208, 11'd225, 11'd242, 11'd259, 11'd276, 11'd292, 11'd309, 11'd326,
        11'd342, 11'd358, 11'd375, 11'd391, 11'd407, 11'd423, 11'd438, 11'd454, 11'd469, 11'd485,
        11'd500, 11'd515, 11'd530, 11'd545, 11'd559, 11'd574, 11'd588, 11'd602, 11'd616, 11'd629,
        11'd643, 11'd656, 11'd669, 11'd682, 11'd695, 11'd707, 11'd719, 11'd731, 11'd743, 11'd755,
        11'd766, 11'd777, 11'd788, 11'd799, 11'd809, 11'd819, 11'd829, 11'd839, 11'd848, 11'd857,
        11'd866, 11'd875, 11'd883, 11'd891, 11'd899, 11'd906, 11'd914, 11'd921, 11'd927, 11'd934,
        11'd940, 11'd946, 11'd951, 11'd956, 11'd961, 11'd966, 11'd970, 11'd974, 11'd978, 11'd982,
        11'd985, 11'd988, 11'd990, 11'd993, 11'd995, 11'd996, 11'd998, 11'd999, 11'd999, 11'd1000,
        11'd1000
    };

endpackage

// File: rtl/trig_quarter_rom.sv
// Dual-read combinational quarter-wave sine ROM serving the sin and cos lookups in parallel.
module trig_quarter_rom
    import trig_pkg::*;
(
    input  logic [ADDR_W-1:0] i_sin_addr,
    input  logic [ADDR_W-1:0] i_cos_addr,
    output logic [MAG_W-1:0]  o_sin_mag,
    output logic [MAG_W-1:0]  o_cos_mag
);

    // Addresses above 90 never occur after folding; return 0 rather than read past the table.
    always_comb begin
        o_sin_mag = '0;
        o_cos_mag = '0;
        if (i_sin_addr <= ADDR_W'(QUARTER)) o_sin_mag = SIN_TABLE[i_sin_addr];
        if (i_cos_addr <= ADDR_W'(QUARTER)) o_cos_mag = SIN_TABLE[i_cos_addr];
    end

endmodule

// File: rtl/trigonometry_unit.sv
// Registered cos/sin generator: integer degrees in, AMP-scaled signed values out, 1-cycle latency.
// Range reduction, quadrant folding and lookup are combinational ahead of the output registers.
module trigonometry_unit #(
    parameter int AMP       = trig_pkg::AMP,
    parameter int ANGLE_MAX = trig_pkg::ANGLE_MAX
) (
    input  logic               i_clock,
    input  logic               i_RESET,
    input  logic signed [31:0] i_theta,
    output logic signed [31:0] o_cos,
    output logic signed [31:0] o_sin
);

    import trig_pkg::*;

    logic                    in_range;
    logic [8:0]              angle;
    quadrant_e               quad;
    logic [ADDR_W-1:0]       sin_addr;
    logic [ADDR_W-1:0]       cos_addr;
    logic                    sin_neg;
    logic                    cos_neg;
    logic [MAG_W-1:0]        sin_mag;
    logic [MAG_W-1:0]        cos_mag;
    logic signed [MAG_W-1:0] sin_val;
    logic signed [MAG_W-1:0] cos_val;
    logic signed [31:0]      cos_q;
    logic signed [31:0]      sin_q;

    // For in-range inputs the low 9 bits plus 360 (mod 512) give the wrapped angle; -360 lands on 0.
    always_comb begin
        in_range = (i_theta >= -ANGLE_MAX) && (i_theta <= ANGLE_MAX);
        angle    = i_theta[31] ? (i_theta[8:0] + 9'(ANGLE_MAX)) : i_theta[8:0];
        if (!in_range || angle == 9'(ANGLE_MAX)) angle = '0;
    end

    always_comb begin
        if (angle <= 9'd90)       quad = QuadI;
        else if (angle <= 9'd180) quad = QuadII;
        else if (angle <= 9'd270) quad = QuadIII;
        else                      quad = QuadIV;
    end

    always_comb begin
        sin_addr = '0;
        cos_addr = '0;
        sin_neg  = 1'b0;
        cos_neg  = 1'b0;
        unique case (quad)
            QuadI: begin
                sin_addr = ADDR_W'(angle);
                cos_addr = ADDR_W'(9'd90 - angle);
            end
            QuadII: begin
                sin_addr = ADDR_W'(9'd180 - angle);
                cos_addr = ADDR_W'(angle - 9'd90);
                cos_neg  = 1'b1;
            end
            QuadIII: begin
                sin_addr = ADDR_W'(angle - 9'd180);
                cos_addr = ADDR_W'(9'd270 - angle);
                sin_neg  = 1'b1;
                cos_neg  = 1'b1;
            end
            QuadIV: begin
                sin_addr = ADDR_W'(9'd360 - angle);
                cos_addr = ADDR_W'(angle - 9'd270);
                sin_neg  = 1'b1;
            end
            default: ;
        endcase
    end

    trig_quarter_rom u_rom (
        .i_sin_addr (sin_addr),
        .i_cos_addr (cos_addr),
        .o_sin_mag  (sin_mag),
        .o_cos_mag  (cos_mag)
    );

    // Magnitudes are at most 1000, so the 11-bit signed view is always non-negative before negation.
    always_comb begin
        sin_val = sin_neg ? -$signed(sin_mag) : $signed(sin_mag);
        cos_val = cos_neg ? -$signed(cos_mag) : $signed(cos_mag);
    end

    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            cos_q <= 32'(AMP);
            sin_q <= '0;
        end else begin
            cos_q <= {{(32-MAG_W){cos_val[MAG_W-1]}}, cos_val};
            sin_q <= {{(32-MAG_W){sin_val[MAG_W-1]}}, sin_val};
        end
    end

    assign o_cos = cos_q;
    assign o_sin = sin_q;

endmodule

// File: tb/tb_trigonometry_unit.sv
// Self-checking bench for trigonometry_unit: expectations queued at drive time, popped one cycle later.
module tb_trigonometry_unit;

    import trig_pkg::*;

    logic               i_clock;
    logic               i_RESET;
    logic signed [31:0] i_theta;
    logic signed [31:0] o_cos;
    logic signed [31:0] o_sin;

    int n_tests;
    int n_fail;

    typedef struct {
        string tag;
        int    exp_cos;
        int    exp_sin;
    } expect_t;

    expect_t sb_q[$];

    trigonometry_unit u_dut (
        .i_clock (i_clock),
        .i_RESET (i_RESET),
        .i_theta (i_theta),
        .o_cos   (o_cos),
        .o_sin   (o_sin)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Golden model: fold by 90-degree quadrant index and remainder over the shared table.
    function automatic void model(input int theta, output int c, output int s);
        int a;
        int q;
        int r;
        if (theta < -360 || theta > 360) theta = 0;
        a = ((theta % 360) + 360) % 360;
        q = a / 90;
        r = a % 90;
        case (q)
            0:       begin s =  int'(SIN_TABLE[r]);      c =  int'(SIN_TABLE[90 - r]); end
            1:       begin s =  int'(SIN_TABLE[90 - r]); c = -int'(SIN_TABLE[r]);      end
            2:       begin s = -int'(SIN_TABLE[r]);      c = -int'(SIN_TABLE[90 - r]); end
            default: begin s = -int'(SIN_TABLE[90 - r]); c =  int'(SIN_TABLE[r]);      end
        endcase
    endfunction

    // Called #1 after a rising edge: drive, queue expectation, then sample #1 after the next edge.
    task automatic cycle(input int theta, input logic rst, input int exp_c, input int exp_s,
                         input string tag);
        expect_t e;
        expect_t got;
        i_theta = theta;
        i_RESET = rst;
        e.tag     = tag;
        e.exp_cos = exp_c;
        e.exp_sin = exp_s;
        sb_q.push_back(e);
        @(posedge i_clock);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_queue"}, 0, 1);
        end else begin
            got = sb_q.pop_front();
            check({got.tag, "_cos"}, o_cos, got.exp_cos);
            check({got.tag, "_sin"}, o_sin, got.exp_sin);
            check({got.tag, "_bound"}, int'(o_cos >= -1000 && o_cos <= 1000 &&
                                            o_sin >= -1000 && o_sin <= 1000), 1);
        end
    endtask

    task automatic cycle_model(input int theta, input string tag);
        int c;
        int s;
        model(theta, c, s);
        cycle(theta, 1'b0, c, s, tag);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        i_RESET = 1'b1;
        i_theta = 77;
        @(posedge i_clock);
        #1;

        for (int i = 0; i < 3; i++) cycle(77, 1'b1, 1000, 0, "reset_hold");
        cycle(77, 1'b0, 225, 974, "post_reset_77");

        cycle(0,   1'b0, 1000,  0,    "ang_0");
        cycle(30,  1'b0, 866,   500,  "ang_30");
        cycle(90,  1'b0, 0,     1000, "ang_90");
        cycle(135, 1'b0, -707,  707,  "ang_135");
        cycle(180, 1'b0, -1000, 0,    "ang_180");
        cycle(270, 1'b0, 0,     -1000, "ang_270");

        cycle(-90,  1'b0, 0,    -1000, "ang_m90");
        cycle(-360, 1'b0, 1000, 0,     "ang_m360");
        cycle(360,  1'b0, 1000, 0,     "ang_360");
        cycle(359,  1'b0, 1000, -17,   "ang_359");
        cycle(-1,   1'b0, 1000, -17,   "ang_m1");

        cycle(361,          1'b0, 1000, 0, "oor_361");
        cycle(-361,         1'b0, 1000, 0, "oor_m361");
        cycle(32'h7FFF_FFFF, 1'b0, 1000, 0, "oor_max");
        cycle(32'h8000_0000, 1'b0, 1000, 0, "oor_min");

        for (int t = -360; t <= 360; t++) cycle_model(t, $sformatf("sweep_%0d", t));

        cycle(45, 1'b0, 707,  707, "mid_45");
        cycle(45, 1'b1, 1000, 0,   "mid_reset");
        cycle(60, 1'b0, 500,  866, "after_mid_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
